load_queue_mp: RTL and testbench

//  Parametrised, multi-port successor to the single-port load data queue. Circular load queue between

---
 rtl/load_queue_mp_pkg.sv | 24 ++
 rtl/load_queue_mp_age_picker.sv | 22 ++
 rtl/load_queue_mp.sv | 146 ++++++++++++++
 tb/tb_load_queue_mp.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_queue_mp_pkg.sv
// load_queue_mp_pkg: shared widths, entry type and store-clearance rule for the multi-port load queue
package load_queue_mp_pkg;
    localparam int LDQ_MP_DEPTH  = 16;
    localparam int SDQ_MP_DEPTH  = 16;
    localparam int LDQ_MP_ADDR_W = 32;
    localparam int LDQ_IDX_W     = $clog2(LDQ_MP_DEPTH);
    localparam int SDQ_PTR_W     = $clog2(SDQ_MP_DEPTH) + 1;

    typedef logic [LDQ_IDX_W:0]   ldq_ptr_t;
    typedef logic [SDQ_PTR_W-1:0] sdq_ptr_t;

    typedef struct packed {
        logic [LDQ_IDX_W-1:0]     idx;
        logic [LDQ_MP_ADDR_W-1:0] addr;
        sdq_ptr_t                 sdq_mkr;
    } ldq_mp_entry_t;

    // a load is clear of older stores once the SDQ head has reached or passed its dispatch marker
    function automatic logic sdq_cleared(sdq_ptr_t mkr, sdq_ptr_t head);
        sdq_ptr_t diff;
        diff = mkr - head;
        return (diff == '0) || (diff > sdq_ptr_t'(SDQ_MP_DEPTH));
    endfunction
endpackage

// File: rtl/load_queue_mp_age_picker.sv
// ldq_age_picker: combinational oldest-first pick over a request vector, age measured from head
module ldq_age_picker #(
    parameter int DEPTH = 16,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req_i,
    input  logic [IW-1:0]    head_i,
    output logic             found_o,
    output logic [IW-1:0]    idx_o
);
    // scan youngest to oldest so the request closest to head is the last one written
    always_comb begin
        found_o = 1'b0;
        idx_o   = head_i;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (req_i[head_i + IW'(k)]) begin
                found_o = 1'b1;
                idx_o   = head_i + IW'(k);
            end
        end
    end
endmodule

// File: rtl/load_queue_mp.sv
// load_queue_mp: circular load queue with multi-lane dispatch, multi-port address capture and ordered issue
module load_queue_mp
    import load_queue_mp_pkg::*;
#(
    parameter  int DISP_WIDTH   = 2,
    parameter  int EXEC_PORTS   = 2,
    parameter  int RETIRE_WIDTH = 2,
    localparam int RET_W        = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [DISP_WIDTH-1:0]                       disp_vld_i,
    input  sdq_ptr_t [DISP_WIDTH-1:0]                   disp_sdq_mkr_i,
    output logic [DISP_WIDTH-1:0][LDQ_IDX_W-1:0]        disp_ldq_idx_o,
    output logic                                        disp_full_o,
    input  logic [EXEC_PORTS-1:0]                       exec_vld_i,
    input  logic [EXEC_PORTS-1:0][LDQ_IDX_W-1:0]        exec_ldq_idx_i,
    input  logic [EXEC_PORTS-1:0][LDQ_MP_ADDR_W-1:0]    exec_addr_i,
    input  sdq_ptr_t                                    sdq_head_ptr_i,
    output logic                                        issue_vld_o,
    input  logic                                        issue_rdy_i,
    output ldq_mp_entry_t                               issue_entry_o,
    input  logic [RET_W-1:0]                            ret_cnt_i,
    input  logic                                        flush_i,
    output ldq_ptr_t                                    ldq_count_o
);
    localparam int D  = LDQ_MP_DEPTH;
    localparam int FW = LDQ_IDX_W + 2;

    ldq_ptr_t                          head_q, head_d, tail_q, tail_d, count;
    logic [D-1:0]                      vld_q, vld_d, av_q, av_d, iss_q, iss_d, elig;
    logic [D-1:0][LDQ_MP_ADDR_W-1:0]   addr_q, addr_d;
    sdq_ptr_t [D-1:0]                  mkr_q, mkr_d;
    logic [FW-1:0]                     free;
    logic                              disp_ok, issue_ld, found, ret_bad;
    logic [LDQ_IDX_W-1:0]              sel;
    logic                              issue_vld_q;
    ldq_mp_entry_t                     issue_entry_q;

    assign count          = tail_q - head_q;
    assign ldq_count_o    = count;
    assign free           = FW'(D) - FW'(count) + FW'(ret_cnt_i);
    assign disp_full_o    = free < FW'(DISP_WIDTH);
    assign disp_ok        = !disp_full_o && !flush_i;
    assign issue_ld       = !issue_vld_q || issue_rdy_i;
    assign issue_vld_o    = issue_vld_q;
    assign issue_entry_o  = issue_entry_q;

    // per-entry readiness: address known, not yet sent, and no older store still pending
    always_comb begin
        for (int j = 0; j < D; j++)
            elig[j] = vld_q[j] && av_q[j] && !iss_q[j] && sdq_cleared(mkr_q[j], sdq_head_ptr_i);
    end

    ldq_age_picker #(.DEPTH(D)) u_picker (
        .req_i   (elig),
        .head_i  (head_q[LDQ_IDX_W-1:0]),
        .found_o (found),
        .idx_o   (sel)
    );

    // dispatch lanes allocate consecutive slots starting at the tail
    always_comb begin
        for (int i = 0; i < DISP_WIDTH; i++)
            disp_ldq_idx_o[i] = tail_q[LDQ_IDX_W-1:0] + LDQ_IDX_W'(i);
    end

    // next entry state: exec capture, issue mark, retire clear, then dispatch fill; flush wipes validity
    always_comb begin
        vld_d  = vld_q;
        av_d   = av_q;
        iss_d  = iss_q;
        addr_d = addr_q;
        mkr_d  = mkr_q;
        for (int p = EXEC_PORTS - 1; p >= 0; p--) begin
            if (exec_vld_i[p] && vld_q[exec_ldq_idx_i[p]]) begin
                av_d[exec_ldq_idx_i[p]]   = 1'b1;
                addr_d[exec_ldq_idx_i[p]] = exec_addr_i[p];
            end
        end
        if (issue_ld && found) iss_d[sel] = 1'b1;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (RET_W'(k) < ret_cnt_i) begin
                vld_d[head_q[LDQ_IDX_W-1:0] + LDQ_IDX_W'(k)] = 1'b0;
                av_d[head_q[LDQ_IDX_W-1:0] + LDQ_IDX_W'(k)]  = 1'b0;
                iss_d[head_q[LDQ_IDX_W-1:0] + LDQ_IDX_W'(k)] = 1'b0;
            end
        end
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (disp_ok && disp_vld_i[i]) begin
                vld_d[disp_ldq_idx_o[i]] = 1'b1;
                av_d[disp_ldq_idx_o[i]]  = 1'b0;
                iss_d[disp_ldq_idx_o[i]] = 1'b0;
                mkr_d[disp_ldq_idx_o[i]] = disp_sdq_mkr_i[i];
            end
        end
        if (flush_i) vld_d = '0;
        head_d = head_q + ldq_ptr_t'(ret_cnt_i);
        tail_d = flush_i ? head_d : tail_q + (disp_ok ? ldq_ptr_t'($countones(disp_vld_i)) : '0);
    end

    // queue pointers and entry storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            vld_q  <= '0;
            av_q   <= '0;
            iss_q  <= '0;
            addr_q <= '0;
            mkr_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            vld_q  <= vld_d;
            av_q   <= av_d;
            iss_q  <= iss_d;
            addr_q <= addr_d;
            mkr_q  <= mkr_d;
        end
    end

    // one-entry issue buffer: refills when empty or drained, holds steady under backpressure
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_vld_q   <= 1'b0;
            issue_entry_q <= '0;
        end else if (flush_i) begin
            issue_vld_q <= 1'b0;
        end else if (issue_ld) begin
            issue_vld_q <= found;
            if (found) issue_entry_q <= '{idx: sel, addr: addr_q[sel], sdq_mkr: mkr_q[sel]};
        end
    end

    // retiring more than is queued, or an entry that never issued, is a protocol error upstream
    always_comb begin
        ret_bad = ldq_ptr_t'(ret_cnt_i) > count;
        for (int k = 0; k < RETIRE_WIDTH; k++)
            if (RET_W'(k) < ret_cnt_i && !iss_q[head_q[LDQ_IDX_W-1:0] + LDQ_IDX_W'(k)]) ret_bad = 1'b1;
    end

    a_disp_contig: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (disp_vld_i & (disp_vld_i + 1'b1)) == '0);
    a_retire_legal: assert property (@(posedge clk_i) disable iff (!rst_ni) !ret_bad);
endmodule

// File: tb/tb_load_queue_mp.sv
// tb_load_queue_mp: directed scenarios plus randomized traffic against a queue-based reference model
module tb_load_queue_mp;
    import load_queue_mp_pkg::*;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic [1:0]          disp_vld;
    sdq_ptr_t [1:0]      disp_mkr;
    logic [1:0][3:0]     disp_idx;
    logic                disp_full;
    logic [1:0]          exec_vld;
    logic [1:0][3:0]     exec_idx;
    logic [1:0][31:0]    exec_addr;
    sdq_ptr_t            sdq_head;
    logic                issue_vld, issue_rdy;
    ldq_mp_entry_t       issue_entry;
    logic [1:0]          ret_cnt;
    logic                flush;
    ldq_ptr_t            ldq_count;

    always #5 clk_i = ~clk_i;

    load_queue_mp dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .disp_vld_i     (disp_vld),
        .disp_sdq_mkr_i (disp_mkr),
        .disp_ldq_idx_o (disp_idx),
        .disp_full_o    (disp_full),
        .exec_vld_i     (exec_vld),
        .exec_ldq_idx_i (exec_idx),
        .exec_addr_i    (exec_addr),
        .sdq_head_ptr_i (sdq_head),
        .issue_vld_o    (issue_vld),
        .issue_rdy_i    (issue_rdy),
        .issue_entry_o  (issue_entry),
        .ret_cnt_i      (ret_cnt),
        .flush_i        (flush),
        .ldq_count_o    (ldq_count)
    );

    typedef struct {
        int          idx;
        bit          av;
        logic [31:0] addr;
        logic [4:0]  mkr;
        bit          iss;
    } ment_t;

    ment_t         lq[$];
    int            m_head;
    bit            m_iv;
    ldq_mp_entry_t m_ie;
    int            checks = 0;
    int            failures = 0;

    function automatic bit cleared(logic [4:0] mkr, logic [4:0] head);
        int d;
        d = (int'(mkr) - int'(head) + 32) % 32;
        return d == 0 || d > 16;
    endfunction

    function automatic bit m_full();
        return (16 - lq.size() + int'(ret_cnt)) < 2;
    endfunction

    function automatic int lead_issued();
        int n = 0;
        while (n < 2 && n < lq.size() && lq[n].iss) n++;
        return n;
    endfunction

    task automatic m_reset();
        lq.delete();
        m_head = 0;
        m_iv = 0;
        m_ie = '0;
    endtask

    task automatic model_step();
        int pick;
        bit full, ld;
        bit claimed [16];
        pick = -1;
        full = m_full();
        ld = !m_iv || issue_rdy;
        foreach (claimed[j]) claimed[j] = 0;
        foreach (lq[j]) if (pick < 0 && lq[j].av && !lq[j].iss && cleared(lq[j].mkr, sdq_head)) pick = j;
        if (flush) m_iv = 0;
        else begin
            if (ld) begin
                m_iv = (pick >= 0);
                if (pick >= 0) begin
                    m_ie = '{idx: 4'(lq[pick].idx), addr: lq[pick].addr, sdq_mkr: lq[pick].mkr};
                    lq[pick].iss = 1;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (exec_vld[p] && !claimed[exec_idx[p]]) begin
                    claimed[exec_idx[p]] = 1;
                    foreach (lq[j]) if (lq[j].idx == int'(exec_idx[p])) begin
                        lq[j].av = 1;
                        lq[j].addr = exec_addr[p];
                    end
                end
            end
        end
        repeat (int'(ret_cnt)) void'(lq.pop_front());
        m_head += int'(ret_cnt);
        if (flush) lq.delete();
        else if (!full) begin
            for (int i = 0; i < 2; i++) begin
                if (disp_vld[i]) begin
                    ment_t e;
                    e.idx = (m_head + lq.size()) % 16;
                    e.av = 0;
                    e.addr = '0;
                    e.mkr = disp_mkr[i];
                    e.iss = 0;
                    lq.push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic idle();
        disp_vld = '0;
        disp_mkr = '0;
        exec_vld = '0;
        exec_idx = '0;
        exec_addr = '0;
        issue_rdy = 1'b1;
        ret_cnt = '0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ldq_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ldq_count); end
        checks++; if (disp_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", disp_full); end
        checks++; if (issue_vld !== 1'b0) begin failures++; $display("FAIL reset_issue_vld got=%b exp=0", issue_vld); end
        idle(); disp_vld = 2'b11; disp_mkr[0] = sdq_head; disp_mkr[1] = sdq_head;
        tick(); tick();
        disp_vld = 2'b01; tick();
        idle(); exec_vld = 2'b01; exec_idx[0] = 4'd0; exec_addr[0] = 32'h1000;
        tick();
        idle(); tick();
        #1;
        checks++; if (ldq_count !== 5'd5) begin failures++; $display("FAIL pre_reset_count got=%0d exp=5", ldq_count); end
        checks++; if (issue_vld !== 1'b1) begin failures++; $display("FAIL pre_reset_issue got=%b exp=1", issue_vld); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (ldq_count !== 5'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", ldq_count); end
        checks++; if (issue_vld !== 1'b0) begin failures++; $display("FAIL async_reset_issue got=%b exp=0", issue_vld); end
        checks++; if (issue_entry !== '0) begin failures++; $display("FAIL async_reset_entry got=%h exp=0", issue_entry); end
        checks++; if (disp_full !== 1'b0) begin failures++; $display("FAIL async_reset_full got=%b exp=0", disp_full); end
        m_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_fill();
        idle();
        for (int k = 0; k < 8; k++) begin
            disp_vld = 2'b11; disp_mkr[0] = sdq_head; disp_mkr[1] = sdq_head;
            #1;
            checks++; if (disp_idx[0] !== 4'(2*k) || disp_idx[1] !== 4'(2*k+1))
                begin failures++; $display("FAIL fill_idx k=%0d got=%0d,%0d exp=%0d,%0d", k, disp_idx[0], disp_idx[1], 2*k, 2*k+1); end
            checks++; if (disp_full !== 1'b0) begin failures++; $display("FAIL fill_not_full k=%0d got=%b exp=0", k, disp_full); end
            tick();
        end
        #1;
        checks++; if (disp_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", disp_full); end
        checks++; if (ldq_count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", ldq_count); end
        tick();
        #1;
        checks++; if (ldq_count !== 5'd16) begin failures++; $display("FAIL fill_ninth_ignored got=%0d exp=16", ldq_count); end
        idle(); flush = 1'b1; tick();
        idle(); #1;
        checks++; if (ldq_count !== 5'd0) begin failures++; $display("FAIL fill_flush_count got=%0d exp=0", ldq_count); end
    endtask

    task automatic test_ooo_exec();
        for (int v = 0; v < 2; v++) begin
            int b;
            logic [3:0] first, second;
            b = (m_head + lq.size()) % 16;
            first  = (v == 0) ? 4'(b + 3) : 4'(b + 1);
            second = (v == 0) ? 4'(b + 1) : 4'(b + 3);
            idle(); disp_vld = 2'b11; disp_mkr[0] = sdq_head; disp_mkr[1] = sdq_head;
            tick(); tick();
            idle(); exec_vld = 2'b01; exec_idx[0] = 4'(b + 3); exec_addr[0] = 32'h3333_0000;
            if (v == 1) begin exec_vld = 2'b11; exec_idx[1] = 4'(b + 1); exec_addr[1] = 32'h1111_0000; end
            tick();
            idle();
            if (v == 0) begin exec_vld = 2'b01; exec_idx[0] = 4'(b + 1); exec_addr[0] = 32'h1111_0000; end
            tick();
            idle(); #1;
            checks++; if (issue_vld !== 1'b1 || issue_entry.idx !== first)
                begin failures++; $display("FAIL ooo_first v=%0d got=%b/%0d exp=1/%0d", v, issue_vld, issue_entry.idx, first); end
            tick(); #1;
            checks++; if (issue_vld !== 1'b1 || issue_entry.idx !== second)
                begin failures++; $display("FAIL ooo_second v=%0d got=%b/%0d exp=1/%0d", v, issue_vld, issue_entry.idx, second); end
            checks++; if (issue_entry.addr !== 32'h1111_0000 && second == 4'(b + 1))
                begin failures++; $display("FAIL ooo_addr v=%0d got=%h exp=11110000", v, issue_entry.addr); end
            flush = 1'b1; tick(); idle();
        end
    endtask

    task automatic test_store_gate();
        logic [4:0] hd [2] = '{5'd3, 5'd17};
        logic [4:0] go [2] = '{5'd5, 5'd1};
        for (int r = 0; r < 2; r++) begin
            int b;
            b = (m_head + lq.size()) % 16;
            idle(); sdq_head = hd[r]; disp_vld = 2'b01; disp_mkr[0] = go[r];
            tick();
            idle(); exec_vld = 2'b01; exec_idx[0] = 4'(b); exec_addr[0] = 32'hA5A5_0000 + 32'(r);
            tick();
            idle();
            for (int c = 0; c < 3; c++) begin
                #1;
                checks++; if (issue_vld !== 1'b0) begin failures++; $display("FAIL store_gate_hold r=%0d c=%0d got=%b exp=0", r, c, issue_vld); end
                tick();
            end
            sdq_head = go[r]; #1;
            checks++; if (issue_vld !== 1'b0) begin failures++; $display("FAIL store_gate_same_cycle r=%0d got=%b exp=0", r, issue_vld); end
            tick(); #1;
            checks++; if (issue_vld !== 1'b1 || issue_entry.sdq_mkr !== go[r] || issue_entry.idx !== 4'(b))
                begin failures++; $display("FAIL store_gate_release r=%0d got=%b/%0d/%0d exp=1/%0d/%0d", r, issue_vld, issue_entry.idx, issue_entry.sdq_mkr, b, go[r]); end
            ret_cnt = 2'd1; tick(); idle();
        end
    endtask

    task automatic test_backpressure();
        int b;
        ldq_mp_entry_t exp;
        b = (m_head + lq.size()) % 16;
        idle(); issue_rdy = 1'b0; disp_vld = 2'b11; disp_mkr[0] = sdq_head; disp_mkr[1] = sdq_head;
        tick();
        idle(); issue_rdy = 1'b0; exec_vld = 2'b11; exec_idx[0] = 4'(b); exec_idx[1] = 4'(b);
        exec_addr[0] = 32'hDEAD_0000; exec_addr[1] = 32'hBEEF_1111;
        tick();
        idle(); issue_rdy = 1'b0; exec_vld = 2'b01; exec_idx[0] = 4'(b + 1); exec_addr[0] = 32'h2222_2222;
        tick();
        idle(); issue_rdy = 1'b0;
        exp = '{idx: 4'(b), addr: 32'hDEAD_0000, sdq_mkr: sdq_head};
        #1;
        checks++; if (issue_vld !== 1'b1 || issue_entry !== exp)
            begin failures++; $display("FAIL bp_dual_exec got=%b/%h exp=1/%h", issue_vld, issue_entry, exp); end
        for (int c = 0; c < 4; c++) begin
            tick(); #1;
            checks++; if (issue_vld !== 1'b1 || issue_entry !== exp)
                begin failures++; $display("FAIL bp_stable c=%0d got=%b/%h exp=1/%h", c, issue_vld, issue_entry, exp); end
        end
        issue_rdy = 1'b1; tick(); #1;
        checks++; if (issue_vld !== 1'b1 || issue_entry.idx !== 4'(b + 1) || issue_entry.addr !== 32'h2222_2222)
            begin failures++; $display("FAIL bp_next got=%b/%0d/%h exp=1/%0d/22222222", issue_vld, issue_entry.idx, issue_entry.addr, 4'(b + 1)); end
        ret_cnt = 2'd2; tick(); idle(); #1;
        checks++; if (ldq_count !== 5'd0) begin failures++; $display("FAIL bp_drain got=%0d exp=0", ldq_count); end
    endtask

    task automatic test_wrap_flush();
        int cand[$];
        int exp_head;
        for (int c = 0; c < 100 && m_head <= 20; c++) begin
            cand = {};
            foreach (lq[j]) if (!lq[j].av) cand.push_back(lq[j].idx);
            idle(); disp_vld = 2'b11; disp_mkr[0] = sdq_head; disp_mkr[1] = sdq_head;
            for (int p = 0; p < 2 && p < cand.size(); p++) begin
                exec_vld[p] = 1'b1; exec_idx[p] = 4'(cand[p]); exec_addr[p] = $urandom();
            end
            ret_cnt = 2'(lead_issued());
            #1;
            checks++; if (ldq_count !== ldq_ptr_t'(lq.size())) begin failures++; $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, ldq_count, lq.size()); end
            tick();
        end
        checks++; if (m_head <= 20) begin failures++; $display("FAIL wrap_progress got=%0d exp=>20", m_head); end
        idle(); disp_vld = 2'b11; disp_mkr[0] = sdq_head; disp_mkr[1] = sdq_head;
        ret_cnt = 2'(lead_issued()); flush = 1'b1;
        exp_head = m_head + int'(ret_cnt);
        tick();
        idle(); #1;
        checks++; if (ldq_count !== 5'd0) begin failures++; $display("FAIL wrap_flush_count got=%0d exp=0", ldq_count); end
        checks++; if (disp_idx[0] !== 4'(exp_head % 16)) begin failures++; $display("FAIL wrap_flush_tail got=%0d exp=%0d", disp_idx[0], exp_head % 16); end
        checks++; if (issue_vld !== 1'b0) begin failures++; $display("FAIL wrap_flush_issue got=%b exp=0", issue_vld); end
    endtask

    task automatic test_random();
        int cand[$];
        for (int c = 0; c < 1500; c++) begin
            int u;
            cand = {};
            foreach (lq[j]) if (!lq[j].av) cand.push_back(lq[j].idx);
            idle();
            u = $urandom_range(0, 2);
            disp_vld = (u == 0) ? 2'b00 : (u == 1) ? 2'b01 : 2'b11;
            disp_mkr[0] = sdq_head + 5'($urandom_range(0, 3));
            disp_mkr[1] = sdq_head + 5'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                exec_addr[p] = $urandom();
                if ($urandom_range(0, 9) == 0) begin
                    exec_vld[p] = 1'b1; exec_idx[p] = 4'($urandom_range(0, 15));
                end else if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                    int s;
                    s = $urandom_range(0, cand.size() - 1);
                    exec_vld[p] = 1'b1; exec_idx[p] = 4'(cand[s]);
                end
            end
            issue_rdy = $urandom_range(0, 3) != 0;
            ret_cnt = 2'($urandom_range(0, lead_issued()));
            flush = $urandom_range(0, 49) == 0;
            #1;
            checks++; if (ldq_count !== ldq_ptr_t'(lq.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, ldq_count, lq.size()); end
            checks++; if (disp_full !== m_full()) begin failures++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, disp_full, m_full()); end
            checks++; if (disp_idx[1] !== 4'((m_head + lq.size() + 1) % 16)) begin failures++; $display("FAIL rnd_disp_idx c=%0d got=%0d exp=%0d", c, disp_idx[1], (m_head + lq.size() + 1) % 16); end
            checks++; if (issue_vld !== m_iv) begin failures++; $display("FAIL rnd_issue_vld c=%0d got=%b exp=%b", c, issue_vld, m_iv); end
            if (m_iv) begin
                checks++; if (issue_entry !== m_ie) begin failures++; $display("FAIL rnd_issue_entry c=%0d got=%h exp=%h", c, issue_entry, m_ie); end
            end
            tick();
            if ($urandom_range(0, 2) == 0) sdq_head = sdq_head + 5'd1;
        end
    endtask

    initial begin
        sdq_head = '0;
        idle();
        m_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        test_reset();
        test_fill();
        test_ooo_exec();
        test_store_gate();
        test_backpressure();
        test_wrap_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
